// File: rtl/log_pkg.sv
// Shared widths, result type and register reset values
// for the floor(log2) block.
package log_pkg;
  localparam int W_IN_DEF  = 8;
  localparam int W_OUT_DEF = 3;

  typedef logic [W_OUT_DEF-1:0] result_t;

  localparam result_t RESULT_RST = '0;
  localparam logic    ZERO_RST   = 1'b1;
  localparam logic    POW2_RST   = 1'b0;
endpackage

// File: rtl/log_if.sv
// Operand/result bundle between the log block and its user.
// The master drives number; the slave returns results.
interface log_if
  import log_pkg::*;
#(
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF
);
  logic [W_IN-1:0]  number;
  logic [W_OUT-1:0] result;
  logic             zero;
  logic             pow2;
  logic [W_OUT-1:0] result_q;
  logic             zero_q;
  logic             pow2_q;

  modport master (
    output number,
    input  result, zero, pow2,
    input  result_q, zero_q, pow2_q
  );

  modport slave (
    input  number,
    output result, zero, pow2,
    output result_q, zero_q, pow2_q
  );
endinterface

// File: rtl/log_msb_enc.sv
// Most-significant-set-bit priority encoder as a balanced
// binary tree stored heap-style (node n -> 2n, 2n+1).
module log_msb_enc #(
  parameter int W  = 8,
  parameter int OW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  in_i,
  output logic [OW-1:0] index_o,
  output logic          any_o
);
  localparam int L = $clog2(W);
  localparam int P = 1 << L;

  logic          any_h [1:2*P-1];
  logic [OW-1:0] idx_h [1:2*P-1];

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < W) begin : g_in
      assign any_h[P+i] = in_i[i];
    end else begin : g_pad
      assign any_h[P+i] = 1'b0;
    end
    assign idx_h[P+i] = '0;
  end

  // Upper half wins whenever it has any bit set; its
  // subtree index gains the bit for this level.
  for (genvar n = 1; n < P; n++) begin : g_node
    localparam int H = L - ($clog2(n + 1) - 1);
    assign any_h[n] = any_h[2*n] | any_h[2*n+1];
    assign idx_h[n] = any_h[2*n+1]
                    ? (idx_h[2*n+1] | OW'(1 << (H - 1)))
                    : idx_h[2*n];
  end

  assign index_o = idx_h[1];
  assign any_o   = any_h[1];
endmodule

// File: rtl/log.sv
// floor(log2(number)) with zero/power-of-two flags, both
// combinational and as 1-cycle registered copies.
module log
  import log_pkg::*;
#(
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF
) (
  input logic clk,
  input logic reset,
  log_if.slave bus
);
  logic [W_OUT-1:0] result_d;
  logic             any;
  logic             zero_d;
  logic             pow2_d;

  logic [W_OUT-1:0] result_q;
  logic             zero_q;
  logic             pow2_q;

  log_msb_enc #(
    .W  (W_IN),
    .OW (W_OUT)
  ) u_enc (
    .in_i    (bus.number),
    .index_o (result_d),
    .any_o   (any)
  );

  assign zero_d = ~any;
  assign pow2_d = any &
    ((bus.number & (bus.number - W_IN'(1))) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= W_OUT'(RESULT_RST);
      zero_q   <= ZERO_RST;
      pow2_q   <= POW2_RST;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      pow2_q   <= pow2_d;
    end
  end

  assign bus.result   = result_d;
  assign bus.zero     = zero_d;
  assign bus.pow2     = pow2_d;
  assign bus.result_q = result_q;
  assign bus.zero_q   = zero_q;
  assign bus.pow2_q   = pow2_q;
endmodule

// File: tb/tb_log.sv
// Table vectors, sweep and reset sequences for log, with a
// queue of expected registered outputs.
module tb_log;
  logic clk;
  logic reset;

  log_if #(.W_IN(8), .W_OUT(3)) bus ();

  log #(.W_IN(8), .W_OUT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] r;
    logic       z;
    logic       p;
  } exp_t;

  typedef struct {
    logic [7:0] n;
    logic [2:0] r;
    logic       z;
    logic       p;
  } vec_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int flog2(input int v);
    int r;
    r = 0;
    while (v > 1) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  task automatic apply(input logic [7:0] n,
                       input logic       rst,
                       input logic [2:0] er,
                       input logic       ez,
                       input logic       ep);
    exp_t e;
    bus.number = n;
    reset      = rst;
    #1;
    chk("result", 32'(bus.result), 32'(er));
    chk("zero", 32'(bus.zero), 32'(ez));
    chk("pow2", 32'(bus.pow2), 32'(ep));
    if (rst) e = '{3'd0, 1'b1, 1'b0};
    else     e = '{er, ez, ep};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: got empty expected entry");
    end else begin
      e = sb.pop_front();
      chk("result_q", 32'(bus.result_q), 32'(e.r));
      chk("zero_q", 32'(bus.zero_q), 32'(e.z));
      chk("pow2_q", 32'(bus.pow2_q), 32'(e.p));
    end
  endtask

  task automatic apply_model(input int n, input logic rst);
    apply(8'(n), rst, 3'(flog2(n)), n == 0,
          $countones(8'(n)) == 1);
  endtask

  vec_t vecs[9];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{8'd0,   3'd0, 1'b1, 1'b0};
    vecs[1] = '{8'd1,   3'd0, 1'b0, 1'b1};
    vecs[2] = '{8'd2,   3'd1, 1'b0, 1'b1};
    vecs[3] = '{8'd3,   3'd1, 1'b0, 1'b0};
    vecs[4] = '{8'd4,   3'd2, 1'b0, 1'b1};
    vecs[5] = '{8'd7,   3'd2, 1'b0, 1'b0};
    vecs[6] = '{8'd8,   3'd3, 1'b0, 1'b1};
    vecs[7] = '{8'd128, 3'd7, 1'b0, 1'b1};
    vecs[8] = '{8'd255, 3'd7, 1'b0, 1'b0};

    bus.number = '0;
    reset      = 1'b1;
    // Reset state with a nonzero operand present.
    apply(8'd5, 1'b1, 3'd2, 1'b0, 1'b0);
    apply(8'd0, 1'b1, 3'd0, 1'b1, 1'b0);

    foreach (vecs[i])
      apply(vecs[i].n, 1'b0, vecs[i].r,
            vecs[i].z, vecs[i].p);

    for (int i = 0; i < 256; i++) apply_model(i, 1'b0);
    apply(8'd0, 1'b0, 3'd0, 1'b1, 1'b0);

    apply(8'd200, 1'b0, 3'd7, 1'b0, 1'b0);
    apply(8'd200, 1'b1, 3'd7, 1'b0, 1'b0);
    apply(8'd200, 1'b0, 3'd7, 1'b0, 1'b0);

    apply(8'd200, 1'b1, 3'd7, 1'b0, 1'b0);
    apply(8'd64,  1'b0, 3'd6, 1'b0, 1'b1);
    apply(8'd9,   1'b0, 3'd3, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      apply_model($urandom_range(255), 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/log.md
LOG -- requirements
Module: log

Interface
REQ-001 Parameter W_IN, default 8, width of the input operand.
REQ-002 Parameter W_OUT, default 3, width of the log result, equal to clog2(W_IN).
REQ-003 The interface SHALL comprise the following ports:
- clk  input  1  single clock; all registers update on its rising edge.
- reset  input  1  synchronous, active-high reset.
- number  input  W_IN  unsigned operand.
- result  output  W_OUT  combinational floor(log2(number)).
- zero  output  1  combinational; high when number == 0.
- pow2  output  1  combinational; high when number has exactly one bit set.
- result_q  output  W_OUT  registered copy of result.
- zero_q  output  1  registered copy of zero.
- pow2_q  output  1  registered copy of pow2.

Function
REQ-004 result SHALL be the index of the most significant set bit of number.
REQ-005 For number == 0, result SHALL be 0 and zero SHALL be 1. This is the only case where zero is 1.
REQ-006 result, zero and pow2 SHALL be purely combinational from number, with zero clock latency. They SHALL be valid in the same cycle the input is applied, including when sampled at a rising clk edge before number changes.
REQ-007 pow2 SHALL be 1 iff number is nonzero and number equals (1 << result).
REQ-008 result_q, zero_q and pow2_q SHALL load result, zero and pow2 on every rising clk edge when reset is low, giving 1-cycle latency.
REQ-009 No enable or handshake SHALL exist; a new operand is accepted every cycle.
REQ-010 The block SHALL handle every value 0..2^W_IN-1 without X/Z on any output.
REQ-011 No internal state other than the *_q registers SHALL exist.
REQ-012 Sequencing when number wraps from all-ones to 0:
- result goes from W_IN-1 to 0 and zero goes to 1 in the same cycle.
- The registered copies follow one edge later.

Reset
REQ-013 While reset is high at a rising clk edge, result_q, zero_q and pow2_q SHALL be set to their reset values:
- result_q = 0.
- zero_q = 1.
- pow2_q = 0.
REQ-014 Reset SHALL NOT affect the combinational outputs.
REQ-015 After reset deasserts, the first rising edge SHALL capture the current number normally.
REQ-016 Reset asserted mid-stream SHALL override capture at that edge.
REQ-017 The behaviour of the block with reset left undriven is out of scope; the combinational outputs SHALL still function in that case.

Structure
REQ-018 Package log_pkg SHALL hold:
- W_IN and W_OUT defaults.
- The result type (logic [W_OUT-1:0]).
- The reset constants for result_q, zero_q and pow2_q.
REQ-019 One sub-module, log_msb_enc, SHALL be used:
- It is a parameterised most-significant-bit priority encoder built as a log-depth tree.
- Its outputs are index and any (any = OR of all input bits).
- log instantiates it and derives zero = ~any.
- pow2 = any & ((number & (number - 1)) == 0).
REQ-020 All sequential logic SHALL reside in a single clocked process in log.

Verification
REQ-021 Apply number=0 -> result=0, zero=1, pow2=0; next edge: result_q=0, zero_q=1.
REQ-022 Apply number=1, 2, 3, 4, 7, 8 -> result = 0, 1, 1, 2, 2, 3 and pow2 = 1, 1, 0, 1, 0, 1.
REQ-023 Apply number=128 and 255 -> result=7 for both, pow2=1 then 0; the *_q outputs match one edge later.
REQ-024 Sweep number 0..255 by incrementing after each rising edge, then wrap to 0:
- At every edge result equals floor(log2(number)) (0 for 0).
- zero asserts only at 0.
REQ-025 Hold number=200 and assert reset for one edge -> result_q=0, zero_q=1, pow2_q=0 while result=7. After release, the next edge gives result_q=7, zero_q=0.
REQ-026 Change number at the same edge that reset deasserts -> the registered outputs reflect the new value only from the following edge.
